// File: rtl/analog_conditioner_pkg.sv
// Shared types and constants for the analog stick conditioner.
package analog_cond_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DZ_X,
        ST_FLT_X,
        ST_DZ_Y,
        ST_FLT_Y,
        ST_COMMIT
    } cond_state_t;

    localparam logic [7:0] CENTER   = 8'h80;
    localparam int         AXIS_MAX = 127;

    typedef logic signed [8:0] axis_t;

    // Signed axis value to offset-binary byte (low 8 bits of v + 0x80).
    function automatic logic [7:0] to_offset(input axis_t v);
        return v[7:0] + CENTER;
    endfunction

endpackage

// File: rtl/analog_conditioner_axis_filter.sv
// Combinational deadzone/clamp/invert and first-order filter step for one axis.
module axis_filter
    import analog_cond_pkg::*;
#(
    parameter int DEADZONE = 8,
    parameter int FILT_K   = 2
) (
    input  logic [7:0] raw,
    input  logic       invert,
    input  axis_t      c_in,
    input  axis_t      f_in,
    output axis_t      c_out,
    output axis_t      f_next
);

    axis_t             v;
    axis_t             mag;
    logic signed [9:0] d;
    logic signed [9:0] s;
    logic signed [9:0] sum;

    always_comb begin
        v = {raw[7], raw};
        if (v == -axis_t'(AXIS_MAX + 1)) begin
            v = -axis_t'(AXIS_MAX);
        end
        mag = v[8] ? -v : v;
        if (mag <= axis_t'(DEADZONE)) begin
            v = '0;
        end
        if (invert) begin
            v = -v;
        end
        c_out = v;
    end

    // Floor shift alone stalls short of the target for small positive d;
    // forcing a unit step makes the filter land exactly on c.
    always_comb begin
        d = {c_in[8], c_in} - {f_in[8], f_in};
        s = d >>> FILT_K;
        if ((d != '0) && (s == '0)) begin
            s = d[9] ? -10'sd1 : 10'sd1;
        end
        sum    = {f_in[8], f_in} + s;
        f_next = sum[8:0];
    end

endmodule

// File: rtl/analog_conditioner.sv
// Once per frame: sample the stick, condition and smooth both axes, commit atomically.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | wait for vblank rise with enable high
// ST_DZ_X   | deadzone/clamp X into c_reg
// ST_FLT_X  | filter step for X
// ST_DZ_Y   | deadzone/clamp/invert Y into c_reg
// ST_FLT_Y  | filter step for Y
// ST_COMMIT | publish both axes, pulse upd
module analog_conditioner
    import analog_cond_pkg::*;
#(
    parameter int DEADZONE = 8,
    parameter int FILT_K   = 2,
    parameter int INVERT_Y = 1
) (
    input  logic        clk6m,
    input  logic        reset,
    input  logic        vblank,
    input  logic        enable,
    input  logic [15:0] joy_analog,
    output logic [15:0] analog,
    output logic        upd
);

    cond_state_t state;
    cond_state_t state_nxt;

    logic [15:0] sync1;
    logic [15:0] sync2;
    logic        vblank_d;
    logic        rise;
    logic [7:0]  raw_x;
    logic [7:0]  raw_y;
    axis_t       c_reg;
    axis_t       f_x;
    axis_t       f_y;

    logic [7:0]  raw_sel;
    logic        inv_sel;
    axis_t       f_sel;
    axis_t       c_out;
    axis_t       f_next;

    assign rise = vblank & ~vblank_d;

    // Single filter datapath shared by both axes, steered by the FSM state.
    assign raw_sel = (state == ST_DZ_Y) ? raw_y : raw_x;
    assign inv_sel = (state == ST_DZ_Y) && (INVERT_Y != 0);
    assign f_sel   = (state == ST_FLT_Y) ? f_y : f_x;

    axis_filter #(
        .DEADZONE (DEADZONE),
        .FILT_K   (FILT_K)
    ) u_axis_filter (
        .raw    (raw_sel),
        .invert (inv_sel),
        .c_in   (c_reg),
        .f_in   (f_sel),
        .c_out  (c_out),
        .f_next (f_next)
    );

    always_ff @(posedge clk6m) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (rise) state_nxt = ST_DZ_X;
            ST_DZ_X:   state_nxt = ST_FLT_X;
            ST_FLT_X:  state_nxt = ST_DZ_Y;
            ST_DZ_Y:   state_nxt = ST_FLT_Y;
            ST_FLT_Y:  state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (!enable) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk6m) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            vblank_d <= 1'b0;
            raw_x    <= '0;
            raw_y    <= '0;
            c_reg    <= '0;
            f_x      <= '0;
            f_y      <= '0;
            analog   <= {CENTER, CENTER};
            upd      <= 1'b0;
        end else begin
            sync1    <= joy_analog;
            sync2    <= sync1;
            vblank_d <= vblank;
            upd      <= 1'b0;
            if (!enable) begin
                f_x    <= '0;
                f_y    <= '0;
                analog <= {CENTER, CENTER};
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            raw_x <= sync2[7:0];
                            raw_y <= sync2[15:8];
                        end
                    end
                    ST_DZ_X, ST_DZ_Y: c_reg <= c_out;
                    ST_FLT_X:         f_x   <= f_next;
                    ST_FLT_Y:         f_y   <= f_next;
                    ST_COMMIT: begin
                        analog <= {to_offset(f_x), to_offset(f_y)};
                        upd    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_analog_conditioner.sv
// Scoreboard bench for analog_conditioner: default, FILT_K=0, and FILT_K=0 without Y invert.
module tb_analog_conditioner;

    logic        clk6m;
    logic        reset;
    logic        vblank;
    logic        enable;
    logic [15:0] joy_analog;
    logic [15:0] analog, analog_k0, analog_k0n;
    logic        upd, upd_k0, upd_k0n;

    int n_cmp  = 0;
    int n_fail = 0;
    int upd_seen = 0;
    int bm_fx = 0;
    int bm_fy = 0;
    logic [15:0] exp_q[$];

    analog_conditioner dut (
        .clk6m(clk6m), .reset(reset), .vblank(vblank), .enable(enable),
        .joy_analog(joy_analog), .analog(analog), .upd(upd)
    );
    analog_conditioner #(.FILT_K(0)) dut_k0 (
        .clk6m(clk6m), .reset(reset), .vblank(vblank), .enable(enable),
        .joy_analog(joy_analog), .analog(analog_k0), .upd(upd_k0)
    );
    analog_conditioner #(.FILT_K(0), .INVERT_Y(0)) dut_k0n (
        .clk6m(clk6m), .reset(reset), .vblank(vblank), .enable(enable),
        .joy_analog(joy_analog), .analog(analog_k0n), .upd(upd_k0n)
    );

    initial clk6m = 1'b0;
    always #5 clk6m = ~clk6m;

    always @(negedge clk6m) begin
        if (upd === 1'b1) upd_seen <= upd_seen + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cond(input int raw, input bit inv);
        int v = raw;
        if (v == -128) v = -127;
        if (v <= 8 && v >= -8) v = 0;
        if (inv) v = -v;
        return v;
    endfunction

    function automatic int filt(input int c, input int f, input int k);
        int d = c - f;
        int p = 1 << k;
        int s;
        if (d >= 0) s = d / p;
        else        s = -((-d + p - 1) / p);
        if (d > 0 && s == 0) s = 1;
        return f + s;
    endfunction

    function automatic logic [15:0] model_word();
        logic [15:0] w;
        w[15:8] = 8'((bm_fx + 128) & 255);
        w[7:0]  = 8'((bm_fy + 128) & 255);
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk6m);
        reset  = 1'b1;
        vblank = 1'b0;
        repeat (3) @(negedge clk6m);
        reset = 1'b0;
        bm_fx = 0;
        bm_fy = 0;
        exp_q.delete();
    endtask

    // One full frame: present sample, raise vblank, score the commit and its latency.
    task automatic run_frame(input int x, input int y);
        int lat;
        logic [15:0] e;
        @(negedge clk6m);
        joy_analog = {8'(y), 8'(x)};
        vblank = 1'b0;
        repeat (3) @(negedge clk6m);
        bm_fx = filt(cond(x, 1'b0), bm_fx, 2);
        bm_fy = filt(cond(y, 1'b1), bm_fy, 2);
        exp_q.push_back(model_word());
        vblank = 1'b1;
        lat = -1;
        for (int k = 0; k < 16 && lat < 0; k++) begin
            @(negedge clk6m);
            if (upd === 1'b1) lat = k;
        end
        vblank = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL frame_latency: upd after %0d edges, required 5", lat);
        end
        n_cmp++;
        if (analog !== e) begin
            n_fail++;
            $display("FAIL frame_value x=%0d y=%0d: analog=%h required %h", x, y, analog, e);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (analog !== 16'h8080 || analog_k0 !== 16'h8080 || analog_k0n !== 16'h8080) begin
            n_fail++;
            $display("FAIL reset_analog: %h %h %h required 8080", analog, analog_k0, analog_k0n);
        end
        n_cmp++;
        if (upd !== 1'b0 || upd_k0 !== 1'b0 || upd_k0n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_upd: %b%b%b required 000", upd, upd_k0, upd_k0n);
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_frame(100, 0);
        n_cmp++;
        if (analog !== 16'h9980) begin
            n_fail++;
            $display("FAIL basic_first: analog=%h required 9980", analog);
        end
        run_frame(100, 0);
        n_cmp++;
        if (analog !== 16'hAB80) begin
            n_fail++;
            $display("FAIL basic_second: analog=%h required ab80", analog);
        end
    endtask

    task automatic test_small_converge();
        do_reset();
        run_frame(-100, 0);
        n_cmp++;
        if (analog[15:8] !== 8'h67) begin
            n_fail++;
            $display("FAIL neg_x: analog[15:8]=%h required 67", analog[15:8]);
        end
        for (int i = 0; i < 20; i++) run_frame(5, 0);
        n_cmp++;
        if (analog[15:8] !== 8'h80) begin
            n_fail++;
            $display("FAIL deadzone_converge: analog[15:8]=%h required 80", analog[15:8]);
        end
    endtask

    task automatic test_k0();
        run_frame(0, -128);
        n_cmp++;
        if (analog_k0 !== 16'h80FF) begin
            n_fail++;
            $display("FAIL k0_invert: analog=%h required 80ff", analog_k0);
        end
        n_cmp++;
        if (analog_k0n !== 16'h8001) begin
            n_fail++;
            $display("FAIL k0_noinvert: analog=%h required 8001", analog_k0n);
        end
    endtask

    task automatic test_converge_big();
        do_reset();
        for (int i = 0; i < 40; i++) run_frame(100, 0);
        n_cmp++;
        if (analog[15:8] !== 8'hE4) begin
            n_fail++;
            $display("FAIL converge_100: analog[15:8]=%h required e4", analog[15:8]);
        end
        run_frame(100, 0);
        n_cmp++;
        if (analog[15:8] !== 8'hE4) begin
            n_fail++;
            $display("FAIL converge_stable: analog[15:8]=%h required e4", analog[15:8]);
        end
    endtask

    task automatic test_enable_abort();
        int u0;
        @(negedge clk6m);
        joy_analog = {8'd0, 8'sd100};
        repeat (3) @(negedge clk6m);
        u0 = upd_seen;
        vblank = 1'b1;
        repeat (3) @(negedge clk6m);
        enable = 1'b0;
        vblank = 1'b0;
        repeat (10) @(negedge clk6m);
        n_cmp++;
        if (upd_seen != u0) begin
            n_fail++;
            $display("FAIL enable_abort_upd: %0d pulses required 0", upd_seen - u0);
        end
        n_cmp++;
        if (analog !== 16'h8080) begin
            n_fail++;
            $display("FAIL enable_abort_analog: analog=%h required 8080", analog);
        end
        enable = 1'b1;
        bm_fx = 0;
        bm_fy = 0;
        run_frame(100, 0);
    endtask

    task automatic test_reset_abort();
        int u0;
        run_frame(100, 0);
        @(negedge clk6m);
        repeat (3) @(negedge clk6m);
        u0 = upd_seen;
        vblank = 1'b1;
        repeat (2) @(negedge clk6m);
        reset  = 1'b1;
        vblank = 1'b0;
        repeat (2) @(negedge clk6m);
        reset = 1'b0;
        repeat (10) @(negedge clk6m);
        n_cmp++;
        if (upd_seen != u0 || analog !== 16'h8080) begin
            n_fail++;
            $display("FAIL reset_abort: pulses=%0d analog=%h required 0 and 8080", upd_seen - u0, analog);
        end
        bm_fx = 0;
        bm_fy = 0;
        run_frame(100, 0);
    endtask

    task automatic test_reset_rise();
        int lat;
        @(negedge clk6m);
        joy_analog = {8'd0, 8'sd100};
        reset  = 1'b1;
        vblank = 1'b1;
        repeat (3) @(negedge clk6m);
        reset = 1'b0;
        bm_fx = 0;
        bm_fy = 0;
        lat = -1;
        for (int k = 0; k < 16 && lat < 0; k++) begin
            @(negedge clk6m);
            if (upd === 1'b1) lat = k;
        end
        vblank = 1'b0;
        n_cmp++;
        if (lat != 5 || analog !== 16'h8080) begin
            n_fail++;
            $display("FAIL reset_release_rise: lat=%0d analog=%h required 5 and 8080", lat, analog);
        end
    endtask

    task automatic test_vblank_hold();
        int u0;
        @(negedge clk6m);
        joy_analog = {8'sd50, 8'sd60};
        vblank = 1'b0;
        repeat (3) @(negedge clk6m);
        u0 = upd_seen;
        bm_fx = filt(cond(60, 1'b0), bm_fx, 2);
        bm_fy = filt(cond(50, 1'b1), bm_fy, 2);
        vblank = 1'b1;
        repeat (100) @(negedge clk6m);
        vblank = 1'b0;
        repeat (3) @(negedge clk6m);
        n_cmp++;
        if (upd_seen - u0 != 1) begin
            n_fail++;
            $display("FAIL vblank_hold_pulses: %0d required 1", upd_seen - u0);
        end
        n_cmp++;
        if (analog !== model_word()) begin
            n_fail++;
            $display("FAIL vblank_hold_value: analog=%h required %h", analog, model_word());
        end
    endtask

    task automatic test_back_to_back();
        int u0;
        @(negedge clk6m);
        joy_analog = {8'h90, 8'sd20};
        repeat (3) @(negedge clk6m);
        u0 = upd_seen;
        bm_fx = filt(cond(20, 1'b0), bm_fx, 2);
        bm_fy = filt(cond(-112, 1'b1), bm_fy, 2);
        vblank = 1'b1;
        @(negedge clk6m);
        vblank = 1'b0;
        @(negedge clk6m);
        vblank = 1'b1;
        @(negedge clk6m);
        vblank = 1'b0;
        repeat (15) @(negedge clk6m);
        n_cmp++;
        if (upd_seen - u0 != 1) begin
            n_fail++;
            $display("FAIL back_to_back_pulses: %0d required 1", upd_seen - u0);
        end
        n_cmp++;
        if (analog !== model_word()) begin
            n_fail++;
            $display("FAIL back_to_back_value: analog=%h required %h", analog, model_word());
        end
    endtask

    initial begin
        reset      = 1'b1;
        vblank     = 1'b0;
        enable     = 1'b1;
        joy_analog = '0;
        test_reset();
        test_basic();
        test_small_converge();
        test_k0();
        test_converge_big();
        test_enable_abort();
        test_reset_abort();
        test_reset_rise();
        test_vblank_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
